// File: rtl/ascon_pkg.sv
// Shared definitions for the ASCON-128 record sequencer: sizes, fixed
// key/nonce/associated data, state encoding and block addressing.
package ascon_pkg;

   localparam int unsigned NB_BLOCK = 23;
   localparam int unsigned BLOCK_W  = 64;
   localparam int unsigned DATA_W   = BLOCK_W * NB_BLOCK;
   localparam int unsigned KEY_W    = 128;
   localparam int unsigned CNT_W    = 5;
   localparam int unsigned IDX_W    = $clog2(DATA_W);

   localparam logic [KEY_W-1:0]   KEY        = 128'h8A55114D1CB6A9A2BE263D4D7AECAAFF;
   localparam logic [KEY_W-1:0]   NONCE      = 128'h4ED0EC0B98C529B7C8CDDF37BCD0284A;
   localparam logic [BLOCK_W-1:0] AD         = 64'h4120746F20428000;
   localparam logic [CNT_W-1:0]   LAST_BLOCK = CNT_W'(NB_BLOCK - 1);

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      WAIT_INIT,
      SEND_AD,
      WAIT_AD,
      SEND_PT,
      WAIT_PT,
      DONE
   } state_t;

   // LSB index of block k; block 0 occupies the most significant 64 bits
   function automatic logic [IDX_W-1:0] block_base(input logic [CNT_W-1:0] k);
      return IDX_W'(DATA_W - BLOCK_W * (32'(k) + 32'd1));
   endfunction

endpackage

// File: rtl/ascon_ctrl_fsm.sv
// Drives one ASCON-128 core through init, one AD block and NB_BLOCK plaintext
// blocks, collecting ciphertext and tag of a fixed-size record.
module ascon_ctrl_fsm
   import ascon_pkg::*;
(
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               start_i,
   input  logic [DATA_W-1:0]  data_i,
   input  logic               end_associate_i,
   input  logic [BLOCK_W-1:0] cipher_i,
   input  logic               cipher_valid_i,
   input  logic [KEY_W-1:0]   tag_i,
   input  logic               end_tag_i,
   input  logic               end_initialisation_i,
   input  logic               end_cipher_i,
   output logic               init_o,
   output logic               associate_data_o,
   output logic               finalisation_o,
   output logic [BLOCK_W-1:0] data_o,
   output logic               data_valid_o,
   output logic [KEY_W-1:0]   key_o,
   output logic [KEY_W-1:0]   nonce_o,
   output logic [DATA_W-1:0]  cipher_data_o,
   output logic [KEY_W-1:0]   tag_o,
   output logic               done_o
);

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic               init_n, assoc_n, fin_n, valid_n, done_n;
   logic [BLOCK_W-1:0] data_n;

   assign key_o   = KEY;
   assign nonce_o = NONCE;

   // Next state plus output values derived from the state being entered
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         IDLE:      if (start_i) begin
                       state_n = INIT;
                       cnt_n   = '0;
                    end
         INIT:      state_n = WAIT_INIT;
         WAIT_INIT: if (end_initialisation_i) state_n = SEND_AD;
         SEND_AD:   state_n = WAIT_AD;
         WAIT_AD:   if (end_associate_i) state_n = SEND_PT;
         SEND_PT:   state_n = WAIT_PT;
         WAIT_PT:   if (cnt == LAST_BLOCK) begin
                       if (end_tag_i) state_n = DONE;
                    end else if (end_cipher_i) begin
                       cnt_n   = cnt + CNT_W'(1);
                       state_n = SEND_PT;
                    end
         DONE:      if (!start_i) state_n = IDLE;
         default:   state_n = IDLE;
      endcase

      init_n  = (state_n == INIT);
      valid_n = (state_n == SEND_AD) || (state_n == SEND_PT);
      assoc_n = (state_n == SEND_AD) || (state_n == WAIT_AD);
      fin_n   = ((state_n == SEND_PT) || (state_n == WAIT_PT)) && (cnt_n == LAST_BLOCK);
      done_n  = (state_n == DONE);
      data_n  = data_o;
      if (state_n == SEND_AD)
         data_n = AD;
      else if (state_n == SEND_PT)
         data_n = data_i[block_base(cnt_n) +: BLOCK_W];
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state            <= IDLE;
         cnt              <= '0;
         init_o           <= 1'b0;
         data_valid_o     <= 1'b0;
         associate_data_o <= 1'b0;
         finalisation_o   <= 1'b0;
         done_o           <= 1'b0;
         data_o           <= '0;
      end else begin
         state            <= state_n;
         cnt              <= cnt_n;
         init_o           <= init_n;
         data_valid_o     <= valid_n;
         associate_data_o <= assoc_n;
         finalisation_o   <= fin_n;
         done_o           <= done_n;
         data_o           <= data_n;
      end
   end

   // Ciphertext and tag capture; a cipher beat alongside end_tag_i still lands
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         cipher_data_o <= '0;
         tag_o         <= '0;
      end else if (state == WAIT_PT) begin
         if (cipher_valid_i)
            cipher_data_o[block_base(cnt) +: BLOCK_W] <= cipher_i;
         if ((cnt == LAST_BLOCK) && end_tag_i)
            tag_o <= tag_i;
      end
   end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Scoreboard bench for ascon_ctrl_fsm with a behavioural core model that
// answers each request and returns block ^ keystream as ciphertext.
module tb_ascon_ctrl_fsm;

   localparam int unsigned NB   = 23;
   localparam int unsigned DW   = 64 * NB;
   localparam logic [127:0] KEY_C   = 128'h8A55114D1CB6A9A2BE263D4D7AECAAFF;
   localparam logic [127:0] NONCE_C = 128'h4ED0EC0B98C529B7C8CDDF37BCD0284A;
   localparam logic [63:0]  AD_C    = 64'h4120746F20428000;
   localparam logic [127:0] TAG_C   = 128'h0123456789ABCDEFFEDCBA9876543210;

   localparam int PH_IDLE = 0, PH_INIT = 1, PH_AD = 2, PH_PT = 3, PH_PT2 = 4;

   typedef struct packed {
      logic        ad;
      logic        fin;
      logic [63:0] data;
   } req_t;

   typedef struct packed {
      logic [DW-1:0] cipher;
      logic [127:0]  tag;
   } res_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [DW-1:0] din;
   logic          end_associate_i, cipher_valid_i, end_tag_i;
   logic          end_initialisation_i, end_cipher_i;
   logic [63:0]   cipher_i;
   logic [127:0]  tag_i;
   logic          init_o, associate_data_o, finalisation_o, data_valid_o, done_o;
   logic [63:0]   data_o;
   logic [127:0]  key_o, nonce_o, tag_o;
   logic [DW-1:0] cipher_data_o;

   req_t exp_q[$];
   res_t res_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   init_cnt = 0;
   int   dv_cnt   = 0;
   int   ph = PH_IDLE, dly = 0, blk = 0;
   logic [63:0] pt;
   logic        fin;

   ascon_ctrl_fsm dut (
      .clock_i(clk), .reset_i(rst), .start_i(start), .data_i(din),
      .end_associate_i(end_associate_i), .cipher_i(cipher_i),
      .cipher_valid_i(cipher_valid_i), .tag_i(tag_i), .end_tag_i(end_tag_i),
      .end_initialisation_i(end_initialisation_i), .end_cipher_i(end_cipher_i),
      .init_o(init_o), .associate_data_o(associate_data_o),
      .finalisation_o(finalisation_o), .data_o(data_o),
      .data_valid_o(data_valid_o), .key_o(key_o), .nonce_o(nonce_o),
      .cipher_data_o(cipher_data_o), .tag_o(tag_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Frame blocks: first and last are fixed ECG words, the middle is a ramp
   function automatic logic [63:0] ecg_block(input int k, input int v);
      logic [7:0]  b;
      logic [63:0] r;
      b = 8'(32'h40 + k);
      if (k == 0)           r = 64'h5A5B5B5A5A5A5A5A;
      else if (k == NB - 1) r = 64'h5857545252800000;
      else                  r = {8{b}};
      if (v != 0) r = r ^ 64'hC33C_0FF0_A55A_1EE1;
      return r;
   endfunction

   function automatic logic [63:0] ks(input int k);
      return 64'h0F1E2D3C4B5A6978 ^ {48'h0, 8'(k), 8'(k)};
   endfunction

   // Behavioural core: reacts at the falling edge to registered DUT requests
   task automatic core_step();
      end_initialisation_i = 1'b0;
      end_associate_i      = 1'b0;
      cipher_valid_i       = 1'b0;
      end_cipher_i         = 1'b0;
      end_tag_i            = 1'b0;
      tag_i                = '0;
      if (rst) begin
         ph  = PH_IDLE;
         blk = 0;
         return;
      end
      case (ph)
         PH_IDLE:
            if (init_o) begin
               ph = PH_INIT; dly = 3; blk = 0;
            end else if (data_valid_o && associate_data_o) begin
               ph = PH_AD; dly = 2;
            end else if (data_valid_o) begin
               ph = PH_PT; dly = 2; pt = data_o; fin = finalisation_o;
            end
         PH_INIT:
            if (dly == 0) begin end_initialisation_i = 1'b1; ph = PH_IDLE; end
            else dly--;
         PH_AD:
            if (dly == 0) begin end_associate_i = 1'b1; ph = PH_IDLE; end
            else dly--;
         PH_PT:
            if (dly == 0) begin
               cipher_valid_i = 1'b1;
               cipher_i       = pt ^ ks(blk);
               if (fin) begin
                  end_tag_i = 1'b1; tag_i = TAG_C; ph = PH_IDLE;
               end else begin
                  ph = PH_PT2;
               end
            end else begin
               // stray tag strobe mid-record must be ignored
               if (blk == 5 && dly == 1) begin end_tag_i = 1'b1; tag_i = ~TAG_C; end
               dly--;
            end
         PH_PT2: begin
            end_cipher_i = 1'b1; blk++; ph = PH_IDLE;
         end
         default: ph = PH_IDLE;
      endcase
   endtask

   initial begin
      cipher_i = '0;
      forever begin
         @(negedge clk);
         core_step();
      end
   end

   // Monitor: pops expected requests/results when the DUT presents them
   initial begin : monitor
      logic         init_ack;
      logic         done_seen;
      req_t         e;
      res_t         r;
      logic [DW-1:0] a, x;
      init_ack  = 1'b0;
      done_seen = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (rst) begin
            init_ack  = 1'b0;
            done_seen = 1'b0;
            continue;
         end
         if (end_initialisation_i) init_ack = 1'b1;
         if (init_o) begin
            init_cnt++;
            init_ack = 1'b0;
         end
         if (data_valid_o) begin
            dv_cnt++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_valid: got data_o %0h with nothing expected", data_o);
            end else begin
               e = exp_q.pop_front();
               chk("assoc_flag", 128'(associate_data_o), 128'(e.ad));
               chk("data_o", 128'(data_o), 128'(e.data));
               chk("finalisation", 128'(finalisation_o), 128'(e.fin));
               if (e.ad) chk("init_ack_before_ad", 128'(init_ack), 128'd1);
            end
         end
         if (done_o && !done_seen) begin
            done_seen = 1'b1;
            chk("valid_pulses", 128'(dv_cnt), 128'd24);
            chk("init_pulses", 128'(init_cnt), 128'd1);
            if (res_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_done: got done_o=1 with no result expected");
            end else begin
               r = res_q.pop_front();
               a = cipher_data_o;
               x = r.cipher;
               for (int k = 0; k < NB; k++) begin
                  chk($sformatf("cipher_blk%0d", k), 128'(a[DW-1 -: 64]), 128'(x[DW-1 -: 64]));
                  a = a << 64;
                  x = x << 64;
               end
               chk("tag", tag_o, r.tag);
            end
         end
         if (!done_o) done_seen = 1'b0;
      end
   end

   task automatic load_run(input int v);
      req_t          q;
      res_t          r;
      logic [DW-1:0] c;
      din = '0;
      c   = '0;
      q.ad = 1'b1; q.fin = 1'b0; q.data = AD_C;
      exp_q.push_back(q);
      for (int k = 0; k < NB; k++) begin
         din      = {din[DW-65:0], ecg_block(k, v)};
         c        = {c[DW-65:0], ecg_block(k, v) ^ ks(k)};
         q.ad     = 1'b0;
         q.fin    = (k == NB - 1);
         q.data   = ecg_block(k, v);
         exp_q.push_back(q);
      end
      r.cipher = c;
      r.tag    = TAG_C;
      res_q.push_back(r);
      init_cnt = 0;
      dv_cnt   = 0;
   endtask

   task automatic wait_done(input string name);
      int i;
      for (i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (done_o) break;
      end
      if (i == 3000) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: got no done_o within 3000 cycles, expected done_o=1", name);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_init"}, 128'(init_o), 128'd0);
      chk({tag, "_valid"}, 128'(data_valid_o), 128'd0);
      chk({tag, "_assoc"}, 128'(associate_data_o), 128'd0);
      chk({tag, "_fin"}, 128'(finalisation_o), 128'd0);
      chk({tag, "_done"}, 128'(done_o), 128'd0);
      chk({tag, "_data"}, 128'(data_o), 128'd0);
      chk({tag, "_cipher_zero"}, 128'(cipher_data_o == '0), 128'd1);
      chk({tag, "_tag"}, tag_o, 128'd0);
   endtask

   initial begin : main
      int i;
      rst   = 1'b1;
      start = 1'b0;
      din   = '0;
      #100;
      check_idle_outputs("reset");
      chk("reset_key", key_o, KEY_C);
      chk("reset_nonce", nonce_o, NONCE_C);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Full run with start held high past DONE
      load_run(0);
      start = 1'b1;
      wait_done("run0_done");
      repeat (20) @(negedge clk);
      chk("held_start_no_reinit", 128'(init_cnt), 128'd1);
      chk("done_held", 128'(done_o), 128'd1);
      chk("key_const", key_o, KEY_C);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("done_clear", 128'(done_o), 128'd0);

      // Abort with reset while waiting on plaintext block 10
      load_run(0);
      start = 1'b1;
      for (i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (blk == 10 && ph == PH_PT) break;
      end
      if (i == 3000) begin
         n_checks++;
         n_errors++;
         $display("FAIL abort_reach: got no block 10 request within 3000 cycles, expected one");
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_idle_outputs("abort");
      exp_q.delete();
      res_q.delete();
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Fresh run after the abort, different frame contents
      load_run(1);
      start = 1'b1;
      wait_done("run1_done");
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("final_idle", 128'(done_o), 128'd0);
      chk("queue_drained", 128'(exp_q.size()), 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
